// File: rtl/adder_tree_n_if.sv
// Beat/result handshake bundle for adder_tree_n.
// The tree drives the slave side; the PE array / psum buffer use the master side.
`ifndef W_PSUM
`define W_PSUM 24
`endif

interface adder_tree_n_if #(
  parameter int N_IN   = 16,
  parameter int W_IN   = 20,
  parameter int W_PSUM = `W_PSUM,
  parameter int W_OUT  = 32
);
  logic                     vld_i;
  logic                     rdy_o;
  logic [N_IN*W_IN-1:0]     in_flat;
  logic signed [W_PSUM-1:0] psum;
  logic                     mode_i;
  logic                     first_i;
  logic                     last_i;
  logic signed [W_OUT-1:0]  acc_o;
  logic                     vld_o;
  logic                     rdy_i;
  logic                     ovf_o;

  modport master (
    output vld_i, in_flat, psum, mode_i, first_i, last_i, rdy_i,
    input  rdy_o, acc_o, vld_o, ovf_o
  );

  modport slave (
    input  vld_i, in_flat, psum, mode_i, first_i, last_i, rdy_i,
    output rdy_o, acc_o, vld_o, ovf_o
  );
endinterface

// File: rtl/adder_tree_n.sv
// Pipelined N_IN-input signed adder tree with psum add and first/last accumulation.
// Optional saturating final add enabled by defining ADDER_TREE_SAT_EN.
module adder_tree_n #(
  parameter int N_IN   = 16,
  parameter int W_IN   = 20,
  parameter int W_PSUM = `W_PSUM,
  parameter int W_OUT  = 32
) (
  input logic          clk,
  input logic          rst,
  adder_tree_n_if.slave bus
);

  localparam int LG = $clog2(N_IN);

`ifdef ADDER_TREE_SAT_EN
  localparam logic [W_OUT-1:0] SAT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0] SAT_MIN = {1'b1, {(W_OUT-1){1'b0}}};
`endif

  // Returns {clamped_flag, sum}; wraps unless saturation is built in.
  function automatic logic [W_OUT:0] add_fn(input logic signed [W_OUT-1:0] a,
                                            input logic signed [W_OUT-1:0] b);
`ifdef ADDER_TREE_SAT_EN
    logic signed [W_OUT:0] s;
    s = {a[W_OUT-1], a} + {b[W_OUT-1], b};
    if (s[W_OUT] != s[W_OUT-1]) return {1'b1, s[W_OUT] ? SAT_MIN : SAT_MAX};
    return {1'b0, s[W_OUT-1:0]};
`else
    return {1'b0, a + b};
`endif
  endfunction

  logic en;
  logic vld_o_q, vld_o_d;
  logic ovf_o_q, ovf_o_d;
  logic signed [W_OUT-1:0] acc_o_q, acc_o_d;

  assign en        = !vld_o_q || bus.rdy_i;
  assign bus.rdy_o = en;
  assign bus.vld_o = vld_o_q;
  assign bus.acc_o = acc_o_q;
  assign bus.ovf_o = ovf_o_q;

  // Level 0 is the unregistered input slice; level j holds N_IN>>j sums at W_IN+j bits.
  for (genvar j = 0; j <= LG; j++) begin : g_lvl
    logic signed [W_IN+j-1:0] lvl [N_IN>>j];
    if (j == 0) begin : g_src
      for (genvar k = 0; k < N_IN; k++) begin : g_in
        assign lvl[k] = bus.in_flat[k*W_IN +: W_IN];
      end
    end else begin : g_reg
      logic signed [W_IN+j-1:0] lvl_q [N_IN>>j];
      logic signed [W_IN+j-1:0] lvl_d [N_IN>>j];
      always_comb begin
        for (int k = 0; k < (N_IN >> j); k++) begin
          lvl_d[k] = lvl_q[k];
          if (en) begin
            lvl_d[k] = {g_lvl[j-1].lvl[2*k][W_IN+j-2],   g_lvl[j-1].lvl[2*k]} +
                       {g_lvl[j-1].lvl[2*k+1][W_IN+j-2], g_lvl[j-1].lvl[2*k+1]};
          end
        end
      end
      always_ff @(posedge clk) begin
        if (rst) lvl_q <= '{default: '0};
        else     lvl_q <= lvl_d;
      end
      assign lvl = lvl_q;
    end
  end

  // Side-band delay line aligned with tree level j.
  logic                     vld_pipe_q   [1:LG], vld_pipe_d   [1:LG];
  logic                     mode_pipe_q  [1:LG], mode_pipe_d  [1:LG];
  logic                     first_pipe_q [1:LG], first_pipe_d [1:LG];
  logic                     last_pipe_q  [1:LG], last_pipe_d  [1:LG];
  logic signed [W_PSUM-1:0] psum_pipe_q  [1:LG], psum_pipe_d  [1:LG];

  always_comb begin
    vld_pipe_d   = vld_pipe_q;
    mode_pipe_d  = mode_pipe_q;
    first_pipe_d = first_pipe_q;
    last_pipe_d  = last_pipe_q;
    psum_pipe_d  = psum_pipe_q;
    if (en) begin
      for (int s = LG; s >= 2; s--) begin
        vld_pipe_d[s]   = vld_pipe_q[s-1];
        mode_pipe_d[s]  = mode_pipe_q[s-1];
        first_pipe_d[s] = first_pipe_q[s-1];
        last_pipe_d[s]  = last_pipe_q[s-1];
        psum_pipe_d[s]  = psum_pipe_q[s-1];
      end
      vld_pipe_d[1]   = bus.vld_i;
      mode_pipe_d[1]  = bus.mode_i;
      first_pipe_d[1] = bus.first_i;
      last_pipe_d[1]  = bus.last_i;
      psum_pipe_d[1]  = bus.psum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q   <= '{default: 1'b0};
      mode_pipe_q  <= '{default: 1'b0};
      first_pipe_q <= '{default: 1'b0};
      last_pipe_q  <= '{default: 1'b0};
      psum_pipe_q  <= '{default: '0};
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      mode_pipe_q  <= mode_pipe_d;
      first_pipe_q <= first_pipe_d;
      last_pipe_q  <= last_pipe_d;
      psum_pipe_q  <= psum_pipe_d;
    end
  end

  // Final stage: one shared adder; base is the psum unless continuing an accumulation.
  logic signed [W_OUT-1:0] tree_ext, psum_ext, add_base, sum_val;
  logic [W_OUT:0]          add_r;
  logic                    sum_ovf, ovf_stk;
  logic signed [W_OUT-1:0] acc_q, acc_d;
  logic                    acc_open_q, acc_open_d;
  logic                    ovf_acc_q, ovf_acc_d;
  logic                    f_vld, f_mode, f_first, f_last;

  assign tree_ext = W_OUT'(g_lvl[LG].lvl[0]);
  assign psum_ext = W_OUT'(psum_pipe_q[LG]);
  assign f_vld    = vld_pipe_q[LG];
  assign f_mode   = mode_pipe_q[LG];
  assign f_first  = first_pipe_q[LG];
  assign f_last   = last_pipe_q[LG];

  always_comb begin
    add_base   = (f_mode && !f_first) ? acc_q : psum_ext;
    add_r      = add_fn(add_base, tree_ext);
    sum_val    = add_r[W_OUT-1:0];
    sum_ovf    = add_r[W_OUT];
    ovf_stk    = sum_ovf | (!f_first & ovf_acc_q);
    acc_o_d    = acc_o_q;
    vld_o_d    = vld_o_q;
    ovf_o_d    = ovf_o_q;
    acc_d      = acc_q;
    acc_open_d = acc_open_q;
    ovf_acc_d  = ovf_acc_q;
    if (en) begin
      vld_o_d = 1'b0;
      if (f_vld && !f_mode) begin
        acc_o_d = sum_val;
        ovf_o_d = sum_ovf;
        vld_o_d = 1'b1;
      end else if (f_vld) begin
        acc_d      = sum_val;
        acc_open_d = !f_last;
        ovf_acc_d  = f_last ? 1'b0 : ovf_stk;
        if (f_last) begin
          acc_o_d = sum_val;
          ovf_o_d = ovf_stk;
          vld_o_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_o_q    <= '0;
      vld_o_q    <= 1'b0;
      ovf_o_q    <= 1'b0;
      acc_q      <= '0;
      acc_open_q <= 1'b0;
      ovf_acc_q  <= 1'b0;
    end else begin
      acc_o_q    <= acc_o_d;
      vld_o_q    <= vld_o_d;
      ovf_o_q    <= ovf_o_d;
      acc_q      <= acc_d;
      acc_open_q <= acc_open_d;
      ovf_acc_q  <= ovf_acc_d;
    end
  end

endmodule

// File: tb/tb_adder_tree_n.sv
// Randomized and directed bench for adder_tree_n against an arithmetic reference model.
module tb_adder_tree_n;
  localparam int N_IN   = 16;
  localparam int W_IN   = 20;
  localparam int W_PSUM = 24;
  localparam int W_OUT  = 24;

  typedef struct {
    int     v [N_IN];
    longint psum;
    bit     mode, first, last;
  } beat_t;

  typedef struct {
    longint acc;
    bit     ovf;
    int     acyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_tree_n_if #(.N_IN(N_IN), .W_IN(W_IN), .W_PSUM(W_PSUM), .W_OUT(W_OUT)) bus ();
  adder_tree_n #(.N_IN(N_IN), .W_IN(W_IN), .W_PSUM(W_PSUM), .W_OUT(W_OUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int     n_checks = 0, n_errors = 0;
  beat_t  cur;
  beat_t  send_q [$];
  res_t   exp_q  [$];
  longint m_acc = 0;
  bit     m_ovf = 0;
  bit     chk_lat = 0, rnd_stall = 0, rnd_gap = 0;
  int     stall_at = 0, stall_len = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Result of a W_OUT-bit signed add: wrapped, or clamped with a flag.
  function automatic void fit(input longint x, output longint r, output bit o);
    logic signed [W_OUT-1:0] w;
    longint hi, lo;
    hi = (longint'(1) <<< (W_OUT-1)) - 1;
    lo = -(longint'(1) <<< (W_OUT-1));
`ifdef ADDER_TREE_SAT_EN
    o = (x > hi) || (x < lo);
    r = (x > hi) ? hi : (x < lo) ? lo : x;
`else
    w = x[W_OUT-1:0];
    r = w;
    o = 1'b0;
`endif
  endfunction

  function automatic void model_accept(input beat_t b);
    longint t = 0, r;
    bit o;
    for (int k = 0; k < N_IN; k++) t += b.v[k];
    if (!b.mode) begin
      fit(t + b.psum, r, o);
      exp_q.push_back('{acc: r, ovf: o, acyc: cyc});
    end else begin
      fit((b.first ? b.psum : m_acc) + t, r, o);
      m_ovf = o | (b.first ? 1'b0 : m_ovf);
      m_acc = r;
      if (b.last) begin
        exp_q.push_back('{acc: r, ovf: m_ovf, acyc: cyc});
        m_ovf = 0;
      end
    end
  endfunction

  function automatic beat_t mk(input int val, input longint ps, input bit mode, input bit first, input bit last);
    beat_t b;
    for (int k = 0; k < N_IN; k++) b.v[k] = val;
    b.psum = ps; b.mode = mode; b.first = first; b.last = last;
    return b;
  endfunction

  task automatic drive_beat(input beat_t b);
    for (int k = 0; k < N_IN; k++) bus.in_flat[k*W_IN +: W_IN] = b.v[k][W_IN-1:0];
    bus.psum    = b.psum[W_PSUM-1:0];
    bus.mode_i  = b.mode;
    bus.first_i = b.first;
    bus.last_i  = b.last;
  endtask

  task automatic observe();
    res_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_vld_o", bus.vld_o, 0);
    end else if (bus.rdy_i) begin
      e = exp_q.pop_front();
      chk("acc_o", bus.acc_o, e.acc);
      chk("ovf_o", bus.ovf_o, e.ovf);
      if (chk_lat) chk("latency", cyc - e.acyc, 5);
    end else begin
      chk("stall_acc_o", bus.acc_o, exp_q[0].acc);
      chk("stall_rdy_o", bus.rdy_o, 0);
    end
  endtask

  task automatic run(input int max_cyc, input bit must_drain);
    int c = 0;
    bit acc_pend = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0 || bus.vld_i) && c < max_cyc) begin
      @(negedge clk);
      c++;
      if (acc_pend) begin bus.vld_i = 1'b0; acc_pend = 0; end
      if (!bus.vld_i && send_q.size() > 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
        cur = send_q.pop_front();
        drive_beat(cur);
        bus.vld_i = 1'b1;
      end
      if (stall_len > 0 && c >= stall_at && c < stall_at + stall_len) bus.rdy_i = 1'b0;
      else if (rnd_stall) bus.rdy_i = ($urandom_range(0, 3) != 0);
      else bus.rdy_i = 1'b1;
      #1;
      if (bus.vld_o) observe();
      if (bus.vld_i && bus.rdy_o) begin model_accept(cur); acc_pend = 1; end
    end
    if (must_drain) chk("drain", send_q.size() + exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rdy_i = 1'b1;
      #1;
      chk("idle_vld_o", bus.vld_o, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.vld_i = 1'b0;
    bus.rdy_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_q.delete();
    exp_q.delete();
    m_acc = 0;
    m_ovf = 0;
    #1;
    chk("rst_vld_o", bus.vld_o, 0);
    chk("rst_acc_o", bus.acc_o, 0);
    chk("rst_ovf_o", bus.ovf_o, 0);
    chk("rst_rdy_o", bus.rdy_o, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    beat_t b;
    rst = 1'b1;
    bus.vld_i = 1'b0; bus.rdy_i = 1'b1; bus.in_flat = '0; bus.psum = '0;
    bus.mode_i = 1'b0; bus.first_i = 1'b0; bus.last_i = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // pass mode, latency and back-to-back streaming
    chk_lat = 1;
    send_q.push_back(mk(1, 100, 0, 0, 0));
    run(40, 1);
    send_q.push_back(mk(-524288, -1, 0, 0, 0));
    run(40, 1);
    send_q.push_back(mk(524287, 8388607, 0, 0, 0));
    run(40, 1);
    for (int k = 1; k <= 8; k++) send_q.push_back(mk(k, 0, 0, 0, 0));
    run(60, 1);

    // accumulate: basic, single-beat, interleaved pass, re-opened with first
    send_q.push_back(mk(2, 10, 1, 1, 0));
    send_q.push_back(mk(2, 999, 1, 0, 0));
    send_q.push_back(mk(2, 999, 1, 0, 1));
    send_q.push_back(mk(3, -7, 1, 1, 1));
    send_q.push_back(mk(1, 5, 1, 1, 0));
    send_q.push_back(mk(3, 0, 0, 0, 0));
    send_q.push_back(mk(2, 77, 1, 0, 1));
    send_q.push_back(mk(1, 0, 1, 1, 0));
    send_q.push_back(mk(2, 1, 1, 1, 0));
    send_q.push_back(mk(1, 4, 1, 0, 1));
    send_q.push_back(mk(-3, 4, 1, 0, 1));
    run(80, 1);
    chk_lat = 0;

    // backpressure mid-stream
    stall_at = 7; stall_len = 3;
    for (int k = 1; k <= 6; k++) send_q.push_back(mk(k + 10, k, 0, 0, 0));
    run(60, 1);
    stall_len = 0;

    // reset after a completed first beat: acc restarts from zero
    b = mk(0, 10, 1, 1, 0);
    b.v[0] = 40;
    send_q.push_back(b);
    run(20, 1);
    idle(6);
    do_reset();
    b = mk(0, 123, 1, 0, 1);
    b.v[0] = 7;
    send_q.push_back(b);
    run(20, 1);

    // reset with pass beats in flight: nothing may emerge afterwards
    for (int k = 0; k < 3; k++) send_q.push_back(mk(k + 1, 9, 0, 0, 0));
    run(3, 0);
    do_reset();
    idle(8);

    // randomized traffic with stalls and gaps
    rnd_stall = 1; rnd_gap = 1;
    for (int i = 0; i < 300; i++) begin
      int sel = $urandom_range(0, 7);
      for (int k = 0; k < N_IN; k++)
        b.v[k] = (sel == 0) ? 524287 : (sel == 1) ? -524288 :
                 int'($urandom_range(0, (1 << W_IN) - 1)) - (1 << (W_IN - 1));
      b.psum  = longint'($urandom_range(0, (1 << W_PSUM) - 1)) - (longint'(1) << (W_PSUM - 1));
      b.mode  = $urandom_range(0, 1);
      b.first = ($urandom_range(0, 3) == 0);
      b.last  = ($urandom_range(0, 3) == 0);
      send_q.push_back(b);
    end
    run(5000, 1);
    rnd_stall = 0; rnd_gap = 0;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
